// File: rtl/reg_dump.sv
// Scans CPU registers through the debug select port and streams each value out (macro REG_DUMP_SKIP_ZERO_EN drops zero values).
// Latency: first out_valid SETTLE+1 cycles after start is sampled; each further beat SETTLE+1 cycles after the previous transfer.
// Backpressure: a beat is held stable in SEND until out_ready; the scan stalls meanwhile.
module reg_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31,
  parameter int unsigned SETTLE    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode_single,
  input  logic [4:0]  sel_in,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  if (LAST_REG > 31 || FIRST_REG > LAST_REG || SETTLE < 1 || SETTLE > 7) begin : g_bad_params
    $error("reg_dump: illegal FIRST_REG/LAST_REG/SETTLE");
  end

  localparam logic [4:0] FIRST_IDX  = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX   = 5'(LAST_REG);
  localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [2:0] cnt_q, cnt_d;
  logic       single_q, single_d;
  logic       capture;
  logic       advance;
  logic       last_beat;

  // Termination is decided before the increment, so LAST_REG=31 never wraps to 0.
  assign last_beat = single_q || (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    single_d  = single_q;
    capture   = 1'b0;
    advance   = 1'b0;
    reg_sel   = idx_q;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        reg_sel = sel_in;
        busy    = 1'b0;
        if (start) begin
          single_d = mode_single;
          idx_d    = mode_single ? sel_in : FIRST_IDX;
          cnt_d    = SETTLE_CNT;
          state_d  = SEL;
        end
      end
      SEL: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          capture = 1'b1;
`ifdef REG_DUMP_SKIP_ZERO_EN
          if (reg_data == 32'd0) begin
            advance = 1'b1;
          end else begin
            state_d = SEND;
          end
`else
          state_d = SEND;
`endif
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          advance = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A skipped zero takes the same path as a transferred beat.
    if (advance) begin
      if (last_beat) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + 5'd1;
        cnt_d   = SETTLE_CNT;
        state_d = SEL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= 5'd0;
      cnt_q     <= 3'd0;
      single_q  <= 1'b0;
      out_index <= 5'd0;
      out_data  <= 32'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      if (capture) begin
        out_index <= idx_q;
        out_data  <= reg_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: default instance plus a FIRST_REG=8/LAST_REG=10/SETTLE=3 instance.
`timescale 1ns/1ps
module tb_reg_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2, mode_single, out_ready;
  logic [4:0]  sel_in;
  logic [31:0] regs [32];

  logic [4:0]  reg_sel, out_index, reg_sel2, out_index2;
  logic [31:0] reg_data, out_data, reg_data2, out_data2;
  logic        out_valid, busy, done, out_valid2, busy2, done2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0]  idx_log [64];
  logic [31:0] dat_log [64];

  always #5 clk = ~clk;

  assign reg_data  = regs[reg_sel];
  assign reg_data2 = regs[reg_sel2];

  reg_dump dut (
    .clk(clk), .rst(rst), .start(start), .mode_single(mode_single), .sel_in(sel_in),
    .reg_sel(reg_sel), .reg_data(reg_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_data(out_data), .busy(busy), .done(done)
  );

  reg_dump #(.FIRST_REG(8), .LAST_REG(10), .SETTLE(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode_single(mode_single), .sel_in(sel_in),
    .reg_sel(reg_sel2), .reg_data(reg_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_index(out_index2), .out_data(out_data2), .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full-range dump on dut with out_ready held high; logs every transferred beat.
  task automatic run_dump(output int nbeats, output bit got_done, output int done_gap);
    int last;
    nbeats = 0; got_done = 1'b0; done_gap = -1; last = -1;
    mode_single = 1'b0; out_ready = 1'b1; start = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        done_gap = c - last;
        break;
      end
      if (out_valid && out_ready && nbeats < 64) begin
        idx_log[nbeats] = out_index;
        dat_log[nbeats] = out_data;
        nbeats++;
        last = c;
      end
    end
    check("dump_done_seen", 32'(got_done), 32'd1);
  endtask

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] val;
    logic [4:0]  exp_index;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int  nb, gap, lat, stalls, n3, cyc, sel_entry, beats2;
    bit  gd, hit;

    vecs[0] = '{sel: 5'd5,  val: 32'hDEADBEEF, exp_index: 5'd5,  exp_data: 32'hDEADBEEF, exp_lat: 2};
    vecs[1] = '{sel: 5'd0,  val: 32'h00000001, exp_index: 5'd0,  exp_data: 32'h00000001, exp_lat: 2};
    vecs[2] = '{sel: 5'd31, val: 32'hFFFFFFFF, exp_index: 5'd31, exp_data: 32'hFFFFFFFF, exp_lat: 2};
    vecs[3] = '{sel: 5'd17, val: 32'h12345678, exp_index: 5'd17, exp_data: 32'h12345678, exp_lat: 2};
    vecs[4] = '{sel: 5'd10, val: 32'hA5A55A5A, exp_index: 5'd10, exp_data: 32'hA5A55A5A, exp_lat: 2};

    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101;
    rst = 1'b0; start = 1'b0; start2 = 1'b0; mode_single = 1'b0; out_ready = 1'b0; sel_in = 5'd7;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_reg_sel", 32'(reg_sel), 32'd7);
    check("rst_busy2", 32'(busy2), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // Single-register table; each start lands in the idle cycle right after DONE.
    for (int i = 0; i < 5; i++) begin
      mode_single = 1'b1; sel_in = vecs[i].sel; regs[vecs[i].sel] = vecs[i].val;
      #1;
      check("idle_reg_sel", 32'(reg_sel), 32'(vecs[i].sel));
      check("idle_busy", 32'(busy), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; mode_single = 1'b0; sel_in = ~vecs[i].sel;
      #1;
      check("sel_latched", 32'(reg_sel), 32'(vecs[i].exp_index));
      check("sel_busy", 32'(busy), 32'd1);
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("single_latency", 32'(lat), 32'(vecs[i].exp_lat));
      check("single_index", 32'(out_index), 32'(vecs[i].exp_index));
      check("single_data", out_data, vecs[i].exp_data);
      @(negedge clk);
      check("single_done", 32'(done), 32'd1);
      check("single_done_busy", 32'(busy), 32'd1);
      check("single_done_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("single_after_done", 32'(done), 32'd0);
      check("single_after_busy", 32'(busy), 32'd0);
    end
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101;

    // Full dump 0..31
    run_dump(nb, gd, gap);
    check("full_beats", 32'(nb), 32'd32);
    for (int i = 0; i < 32 && i < nb; i++) begin
      check("full_index", 32'(idx_log[i]), 32'(i));
      check("full_data", dat_log[i], 32'(i) * 32'h0101);
    end
    check("full_done_gap", 32'(gap), 32'd1);
    @(negedge clk);
    check("full_done_width", 32'(done), 32'd0);
    check("full_busy_low", 32'(busy), 32'd0);

    // Backpressure on beat 3 for 4 cycles, plus a start while busy
    mode_single = 1'b0; out_ready = 1'b1; start = 1'b1;
    nb = 0; stalls = 0; n3 = 0; gd = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        gd = 1'b1;
        break;
      end
      if (out_valid && out_index == 5'd3 && stalls < 4) begin
        out_ready = 1'b0;
        stalls++;
        check("stall_index", 32'(out_index), 32'd3);
        check("stall_data", out_data, 32'h0303);
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        check("bp_order", 32'(out_index), 32'(nb));
        if (out_index == 5'd3) n3++;
        if (out_index == 5'd15) start = 1'b1;
        nb++;
      end
    end
    out_ready = 1'b1;
    check("bp_done_seen", 32'(gd), 32'd1);
    check("bp_beats", 32'(nb), 32'd32);
    check("bp_beat3_once", 32'(n3), 32'd1);
    check("bp_stalls", 32'(stalls), 32'd4);
    repeat (3) begin
      @(negedge clk);
      check("bp_start_not_queued", 32'(busy), 32'd0);
    end

    // Reset while beat 10 is presented
    mode_single = 1'b0; out_ready = 1'b1; start = 1'b1; hit = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_index == 5'd10) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_mid_reached", 32'(hit), 32'd1);
    rst = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_index", 32'(out_index), 32'd0);
    rst = 1'b1;
    run_dump(nb, gd, gap);
    check("restart_beats", 32'(nb), 32'd32);
    check("restart_first", 32'(idx_log[0]), 32'd0);
    @(negedge clk);

    // Parameterised instance: 8..10, SETTLE=3, repeated starts while busy
    start2 = 1'b1; cyc = 0; sel_entry = 1; beats2 = 0; gd = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      cyc++;
      start2 = 1'b0;
      if (done2) begin
        gd = 1'b1;
        break;
      end
      if (out_valid2) begin
        check("p_latency", 32'(cyc - sel_entry), 32'd4);
        check("p_index", 32'(out_index2), 32'(8 + beats2));
        check("p_data", out_data2, 32'(8 + beats2) * 32'h0101);
        beats2++;
        sel_entry = cyc + 1;
      end
      if (busy2 && (cyc % 3 == 0)) start2 = 1'b1;
    end
    start2 = 1'b0;
    check("p_done_seen", 32'(gd), 32'd1);
    check("p_beats", 32'(beats2), 32'd3);
    repeat (3) begin
      @(negedge clk);
      check("p_start_not_queued", 32'(busy2), 32'd0);
    end

    // Zero-valued registers
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[2] = 32'h22; regs[7] = 32'h77;
    run_dump(nb, gd, gap);
`ifdef REG_DUMP_SKIP_ZERO_EN
    check("skip_beats", 32'(nb), 32'd2);
    check("skip_idx0", 32'(idx_log[0]), 32'd2);
    check("skip_dat0", dat_log[0], 32'h22);
    check("skip_idx1", 32'(idx_log[1]), 32'd7);
    check("skip_dat1", dat_log[1], 32'h77);
    @(negedge clk);
    regs[2] = 32'd0; regs[7] = 32'd0;
    run_dump(nb, gd, gap);
    check("skip_all_zero_beats", 32'(nb), 32'd0);
`else
    check("zero_beats", 32'(nb), 32'd32);
    check("zero_idx4", 32'(idx_log[4]), 32'd4);
    check("zero_dat4", dat_log[4], 32'd0);
    check("zero_dat7", dat_log[7], 32'h77);
`endif
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter FIRST_REG, default 0, SHALL be the first register index scanned in full-dump mode.
REQ-002 Parameter LAST_REG, default 31, SHALL be the last register index scanned; FIRST_REG <= LAST_REG <= 31.
REQ-003 Parameter SETTLE, default 1, range 1-7, SHALL be the cycles reg_sel is held before reg_data is captured.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-low reset.
REQ-006 Port start, input, 1: dump request, sampled only in IDLE.
REQ-007 Port mode_single, input, 1: sampled with start; 1 = dump only register sel_in, 0 = dump FIRST_REG..LAST_REG.
REQ-008 Port sel_in, input, 5: manual register select; single-mode target.
REQ-009 Port reg_sel, output, 5: register select driven to the CPU debug port.
REQ-010 Port reg_data, input, 32: selected register value returned by the CPU debug port, combinational w.r.t. reg_sel.
REQ-011 Port out_valid, output, 1: output beat valid.
REQ-012 Port out_ready, input, 1: sink accepts beat.
REQ-013 Port out_index, output, 5: register index of current beat.
REQ-014 Port out_data, output, 32: captured register value of current beat.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle pulse at dump completion.

Function
REQ-017 States SHALL be IDLE, SEL, SEND, DONE.
REQ-018 In IDLE, reg_sel SHALL equal sel_in combinationally (manual debug view); out_valid, busy, done low.
REQ-019 IDLE -> SEL when start=1; latch mode and index (sel_in if mode_single, else FIRST_REG); settle counter loaded with SETTLE.
REQ-020 In SEL, reg_sel SHALL equal the latched index; counter decrements each cycle; when it reaches 0, reg_data is captured into out_data/out_index and state -> SEND.
REQ-021 Latency: out_valid SHALL first rise SETTLE+1 cycles after the edge sampling start.
REQ-022 In SEND, out_valid=1; out_data and out_index SHALL stay stable until the edge where out_valid&&out_ready.
REQ-023 On transfer: if single mode or index==LAST_REG -> DONE; else index+1, counter reload, -> SEL.
REQ-024 Index arithmetic SHALL be 5-bit; with LAST_REG=31 no wrap to 0 occurs (termination precedes increment).
REQ-025 DONE SHALL last exactly one cycle with done=1, busy=1, then -> IDLE.
REQ-026 start asserted while busy SHALL be ignored, not queued.
REQ-027 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-028 Back-to-back: start high in the cycle after DONE SHALL begin a new dump.

Reset
REQ-029 rst=0 at a clock edge SHALL force IDLE from any state, including mid-dump, discarding the pending beat.
REQ-030 Reset values: out_valid=0, done=0, busy=0, out_index=0, out_data=0, counter=0; reg_sel follows sel_in.

Configuration
REQ-031 Macro REG_DUMP_SKIP_ZERO_EN defined: a captured value of 0 SHALL skip SEND and proceed per REQ-023 as if transferred; done still pulses even if every beat was skipped.
REQ-032 Macro REG_DUMP_SKIP_ZERO_EN undefined: every scanned register SHALL be emitted, zero or not.

Verification
REQ-033 Defaults, regs r[i]=i*16'h0101, out_ready=1, start pulse -> 32 beats, index 0..31 in order, data r[i], done one cycle after beat 31, busy low after done.
REQ-034 mode_single=1, sel_in=5, r5=32'hDEADBEEF, start -> single beat index 5 data 32'hDEADBEEF, out_valid rises 2 cycles after start edge, then done.
REQ-035 out_ready low 4 cycles during beat 3 -> out_valid held, out_data/out_index unchanged, beat 3 transferred exactly once.
REQ-036 rst=0 during SEND of beat 10 -> next cycle out_valid=0, busy=0; new start restarts at index FIRST_REG.
REQ-037 FIRST_REG=8, LAST_REG=10, SETTLE=3, start pulse repeated while busy -> exactly 3 beats (8,9,10), each out_valid rising 4 cycles after entering SEL; extra starts ignored.
REQ-038 REG_DUMP_SKIP_ZERO_EN defined, only r2 and r7 nonzero -> exactly 2 beats (2,7), then done; all-zero file -> 0 beats, done still pulses.
